// File: rtl/d3s_rf_cnt_pkg.sv
// Shared types and constants for the multi-channel RF cycle counter.
package d3s_rf_cnt_pkg;

  localparam int unsigned c_tai_cycles_per_sec = 125000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } t_rf_cnt_state;

  typedef enum logic {
    TRIG_LOAD = 1'b0,
    TRIG_SNAP = 1'b1
  } t_trig_mode;

endpackage

// File: rtl/d3s_rf_counter_channel.sv
// One RF counter channel with a TAI-timed trigger (LOAD or SNAP); 1-cycle latency from tick/match/sample to outputs.
// Backpressure: none, every input is sampled on every clk_i edge.
module d3s_rf_counter_channel
  import d3s_rf_cnt_pkg::*;
#(
  parameter int g_cnt_width    = 32,
  parameter int g_cycles_width = 28
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [g_cycles_width-1:0] tm_cycles,
  input  logic                      rf_tick,
  input  logic                      enable,
  input  logic [g_cnt_width-1:0]    period,
  input  logic [g_cnt_width-1:0]    sync_value,
  input  logic [g_cycles_width-1:0] trig_cycles,
  input  logic                      arm,
  input  logic                      mode,
  input  logic                      disarm,
  input  logic                      sample_p,
  output logic [g_cnt_width-1:0]    count,
  output logic [g_cnt_width-1:0]    snap_rf,
  output logic [g_cnt_width-1:0]    trig_snap,
  output logic                      armed,
  output logic                      done
);

  localparam logic [g_cycles_width-1:0] c_trig_limit = g_cycles_width'(c_tai_cycles_per_sec);
  localparam logic [g_cnt_width-1:0]    c_one        = g_cnt_width'(1);

  t_rf_cnt_state             state_q, state_d;
  t_trig_mode                mode_q;
  logic [g_cnt_width-1:0]    sync_q;
  logic [g_cnt_width-1:0]    count_q;
  logic [g_cycles_width-1:0] trig_q;
  logic                      match;
  logic                      latch_en;
  logic                      fire_load;
  logic                      fire_snap;
  logic                      set_done;

  // Out-of-range trigger values can never be reached by the TAI counter.
  assign match = (trig_q == tm_cycles) && (trig_q < c_trig_limit);
  assign count = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arm && !disarm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (disarm)     state_d = ST_IDLE;
        else if (match) state_d = ST_FIRED;
      end
      ST_FIRED: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    armed     = (state_q == ST_ARMED);
    latch_en  = 1'b0;
    fire_load = 1'b0;
    fire_snap = 1'b0;
    set_done  = 1'b0;
    case (state_q)
      ST_IDLE:  latch_en = arm && !disarm;
      ST_ARMED: begin
        if (!disarm) begin
          if (match) begin
            fire_load = (mode_q == TRIG_LOAD);
            fire_snap = (mode_q == TRIG_SNAP);
          end else begin
            latch_en = arm;
          end
        end
      end
      ST_FIRED: set_done = !disarm;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q    <= TRIG_LOAD;
      sync_q    <= '0;
      trig_q    <= '0;
      done      <= 1'b0;
      trig_snap <= '0;
      snap_rf   <= '0;
      count_q   <= '0;
    end else begin
      if (latch_en) begin
        mode_q <= t_trig_mode'(mode);
        sync_q <= sync_value;
        trig_q <= trig_cycles;
      end
      if (latch_en)      done <= 1'b0;
      else if (set_done) done <= 1'b1;
      if (fire_snap) trig_snap <= count_q;
      if (sample_p)  snap_rf   <= count_q;
      // A load overrides any coincident RF tick.
      if (fire_load) begin
        count_q <= (period != '0) ? (sync_q % period) : sync_q;
      end else if (rf_tick && enable) begin
        if ((period != '0) && (count_q >= period - c_one)) count_q <= '0;
        else                                               count_q <= count_q + c_one;
      end
    end
  end

endmodule

// File: rtl/d3s_rf_counter_mc.sv
// Multi-channel RF counter with a shared snapshot strobe; 1-cycle latency on all outputs.
// Backpressure: none, snapshot and trigger inputs are accepted on any cycle.
module d3s_rf_counter_mc
  import d3s_rf_cnt_pkg::*;
#(
  parameter int g_num_channels = 2,
  parameter int g_cnt_width    = 32,
  parameter int g_cycles_width = 28
) (
  input  logic                                   clk_ref_i,
  input  logic                                   rst_i,
  input  logic [g_cycles_width-1:0]              tm_cycles_i,
  input  logic [g_num_channels-1:0]              rf_tick_i,
  input  logic [g_num_channels-1:0]              enable_i,
  input  logic [g_num_channels*g_cnt_width-1:0]  period_i,
  input  logic [g_num_channels*g_cnt_width-1:0]  sync_value_i,
  input  logic [g_num_channels*g_cycles_width-1:0] trig_cycles_i,
  input  logic [g_num_channels-1:0]              arm_i,
  input  logic [g_num_channels-1:0]              mode_i,
  input  logic [g_num_channels-1:0]              disarm_i,
  input  logic                                   sample_p_i,
  output logic [g_num_channels*g_cnt_width-1:0]  count_o,
  output logic [g_num_channels*g_cnt_width-1:0]  snap_rf_o,
  output logic [g_cycles_width-1:0]              snap_cycles_o,
  output logic                                   snap_valid_o,
  output logic [g_num_channels*g_cnt_width-1:0]  trig_snap_o,
  output logic [g_num_channels-1:0]              armed_o,
  output logic [g_num_channels-1:0]              done_o
);

  for (genvar i = 0; i < g_num_channels; i++) begin : g_ch
    d3s_rf_counter_channel #(
      .g_cnt_width    (g_cnt_width),
      .g_cycles_width (g_cycles_width)
    ) u_ch (
      .clk_i       (clk_ref_i),
      .rst_i       (rst_i),
      .tm_cycles   (tm_cycles_i),
      .rf_tick     (rf_tick_i[i]),
      .enable      (enable_i[i]),
      .period      (period_i[i*g_cnt_width +: g_cnt_width]),
      .sync_value  (sync_value_i[i*g_cnt_width +: g_cnt_width]),
      .trig_cycles (trig_cycles_i[i*g_cycles_width +: g_cycles_width]),
      .arm         (arm_i[i]),
      .mode        (mode_i[i]),
      .disarm      (disarm_i[i]),
      .sample_p    (sample_p_i),
      .count       (count_o[i*g_cnt_width +: g_cnt_width]),
      .snap_rf     (snap_rf_o[i*g_cnt_width +: g_cnt_width]),
      .trig_snap   (trig_snap_o[i*g_cnt_width +: g_cnt_width]),
      .armed       (armed_o[i]),
      .done        (done_o[i])
    );
  end

  // Channel snapshots and this TAI capture share one strobe so they stay coherent.
  always_ff @(posedge clk_ref_i or posedge rst_i) begin
    if (rst_i) begin
      snap_cycles_o <= '0;
      snap_valid_o  <= 1'b0;
    end else begin
      snap_valid_o <= sample_p_i;
      if (sample_p_i) snap_cycles_o <= tm_cycles_i;
    end
  end

endmodule

// File: tb/tb_d3s_rf_counter_mc.sv
// Directed bench for d3s_rf_counter_mc: counting, wrap, LOAD/SNAP triggers, disarm, reset abort, snapshots.
module tb_d3s_rf_counter_mc;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int CW = 28;

  logic              clk_ref_i = 1'b0;
  logic              rst_i;
  logic [CW-1:0]     tm_cycles_i;
  logic [N-1:0]      rf_tick_i, enable_i, arm_i, mode_i, disarm_i;
  logic [N*W-1:0]    period_i, sync_value_i;
  logic [N*CW-1:0]   trig_cycles_i;
  logic              sample_p_i;
  logic [N*W-1:0]    count_o, snap_rf_o, trig_snap_o;
  logic [CW-1:0]     snap_cycles_o;
  logic              snap_valid_o;
  logic [N-1:0]      armed_o, done_o;

  int tests_run    = 0;
  int tests_failed = 0;

  d3s_rf_counter_mc #(
    .g_num_channels (N),
    .g_cnt_width    (W),
    .g_cycles_width (CW)
  ) dut (
    .clk_ref_i     (clk_ref_i),
    .rst_i         (rst_i),
    .tm_cycles_i   (tm_cycles_i),
    .rf_tick_i     (rf_tick_i),
    .enable_i      (enable_i),
    .period_i      (period_i),
    .sync_value_i  (sync_value_i),
    .trig_cycles_i (trig_cycles_i),
    .arm_i         (arm_i),
    .mode_i        (mode_i),
    .disarm_i      (disarm_i),
    .sample_p_i    (sample_p_i),
    .count_o       (count_o),
    .snap_rf_o     (snap_rf_o),
    .snap_cycles_o (snap_cycles_o),
    .snap_valid_o  (snap_valid_o),
    .trig_snap_o   (trig_snap_o),
    .armed_o       (armed_o),
    .done_o        (done_o)
  );

  always #4 clk_ref_i = ~clk_ref_i;

  function automatic logic [W-1:0] cnt(input int ch);
    return count_o[ch*W +: W];
  endfunction

  function automatic logic [W-1:0] snap(input int ch);
    return snap_rf_o[ch*W +: W];
  endfunction

  function automatic logic [W-1:0] tsnap(input int ch);
    return trig_snap_o[ch*W +: W];
  endfunction

  task automatic step();
    @(posedge clk_ref_i);
    #1;
  endtask

  task automatic clear_inputs();
    tm_cycles_i   = '0;
    rf_tick_i     = '0;
    enable_i      = '0;
    arm_i         = '0;
    mode_i        = '0;
    disarm_i      = '0;
    period_i      = '0;
    sync_value_i  = '0;
    trig_cycles_i = '0;
    sample_p_i    = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] p, input logic en);
    period_i[ch*W +: W] = p;
    enable_i[ch]        = en;
  endtask

  // Pulses arm_i for one edge; tm_cycles_i is whatever the caller left it at.
  task automatic arm_ch(input int ch, input logic md, input logic [CW-1:0] trig, input logic [W-1:0] sv);
    arm_i[ch]                 = 1'b1;
    mode_i[ch]                = md;
    trig_cycles_i[ch*CW +: CW] = trig;
    sync_value_i[ch*W +: W]   = sv;
    step();
    arm_i[ch] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i      = 1'b1;
    rf_tick_i  = 2'b11;
    enable_i   = 2'b11;
    arm_i      = 2'b11;
    sample_p_i = 1'b1;
    tm_cycles_i = 28'd77;
    step();
    step();
    tests_run++;
    if (count_o !== '0) begin tests_failed++; $display("FAIL reset_count: got %0h expected 0", count_o); end
    tests_run++;
    if (snap_rf_o !== '0) begin tests_failed++; $display("FAIL reset_snap_rf: got %0h expected 0", snap_rf_o); end
    tests_run++;
    if (snap_cycles_o !== '0) begin tests_failed++; $display("FAIL reset_snap_cycles: got %0d expected 0", snap_cycles_o); end
    tests_run++;
    if (snap_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_snap_valid: got %0b expected 0", snap_valid_o); end
    tests_run++;
    if (trig_snap_o !== '0) begin tests_failed++; $display("FAIL reset_trig_snap: got %0h expected 0", trig_snap_o); end
    tests_run++;
    if (armed_o !== 2'b00) begin tests_failed++; $display("FAIL reset_armed: got %0b expected 00", armed_o); end
    tests_run++;
    if (done_o !== 2'b00) begin tests_failed++; $display("FAIL reset_done: got %0b expected 00", done_o); end
    clear_inputs();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_free_count();
    apply_reset();
    set_ch(0, 32'd100, 1'b1);
    set_ch(1, 32'd0, 1'b1);
    for (int i = 0; i < 250; i++) begin
      tm_cycles_i = CW'(5000 + i);
      rf_tick_i   = 2'b11;
      sample_p_i  = (i == 130);
      step();
      if (i == 130) begin
        tests_run++;
        if (snap(0) !== 32'd30) begin tests_failed++; $display("FAIL snap_p100: got %0d expected 30", snap(0)); end
        tests_run++;
        if (snap(1) !== 32'd130) begin tests_failed++; $display("FAIL snap_free: got %0d expected 130", snap(1)); end
        tests_run++;
        if (snap_cycles_o !== 28'd5130) begin tests_failed++; $display("FAIL snap_cycles: got %0d expected 5130", snap_cycles_o); end
        tests_run++;
        if (snap_valid_o !== 1'b1) begin tests_failed++; $display("FAIL snap_valid_hi: got %0b expected 1", snap_valid_o); end
      end
      if (i == 131) begin
        tests_run++;
        if (snap_valid_o !== 1'b0) begin tests_failed++; $display("FAIL snap_valid_pulse: got %0b expected 0", snap_valid_o); end
      end
    end
    rf_tick_i  = 2'b00;
    sample_p_i = 1'b0;
    step();
    tests_run++;
    if (cnt(0) !== 32'd50) begin tests_failed++; $display("FAIL count_p100: got %0d expected 50", cnt(0)); end
    tests_run++;
    if (cnt(1) !== 32'd250) begin tests_failed++; $display("FAIL count_free: got %0d expected 250", cnt(1)); end
  endtask

  task automatic test_period_change();
    // Continues from test_free_count: ch0=50, ch1=250.
    set_ch(0, 32'd40, 1'b1);
    set_ch(1, 32'd0, 1'b0);
    rf_tick_i = 2'b11;
    step();
    tests_run++;
    if (cnt(0) !== 32'd0) begin tests_failed++; $display("FAIL period_shrink: got %0d expected 0", cnt(0)); end
    step();
    rf_tick_i = 2'b00;
    tests_run++;
    if (cnt(0) !== 32'd1) begin tests_failed++; $display("FAIL period_after_shrink: got %0d expected 1", cnt(0)); end
    tests_run++;
    if (cnt(1) !== 32'd250) begin tests_failed++; $display("FAIL enable_off: got %0d expected 250", cnt(1)); end
  endtask

  task automatic test_wrap_free();
    apply_reset();
    set_ch(0, 32'd0, 1'b1);
    tm_cycles_i = 28'd9;
    arm_ch(0, 1'b0, 28'd10, 32'hFFFF_FFFF);
    tm_cycles_i = 28'd10;
    step();
    tests_run++;
    if (cnt(0) !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL load_max: got %0h expected ffffffff", cnt(0)); end
    tm_cycles_i = 28'd11;
    rf_tick_i   = 2'b01;
    step();
    rf_tick_i = 2'b00;
    tests_run++;
    if (cnt(0) !== 32'd0) begin tests_failed++; $display("FAIL wrap_free: got %0d expected 0", cnt(0)); end
  endtask

  task automatic test_load();
    apply_reset();
    set_ch(0, 32'd512, 1'b1);
    tm_cycles_i = 28'd990;
    rf_tick_i   = 2'b01;
    repeat (3) step();
    rf_tick_i = 2'b00;
    arm_ch(0, 1'b0, 28'd1000, 32'd123);
    tests_run++;
    if (armed_o[0] !== 1'b1) begin tests_failed++; $display("FAIL load_armed: got %0b expected 1", armed_o[0]); end
    for (int t = 991; t < 1000; t++) begin
      tm_cycles_i = CW'(t);
      step();
    end
    tests_run++;
    if (cnt(0) !== 32'd3) begin tests_failed++; $display("FAIL load_premature: got %0d expected 3", cnt(0)); end
    tm_cycles_i = 28'd1000;
    rf_tick_i   = 2'b01;
    step();
    rf_tick_i = 2'b00;
    tests_run++;
    if (cnt(0) !== 32'd123) begin tests_failed++; $display("FAIL load_value: got %0d expected 123", cnt(0)); end
    tests_run++;
    if (armed_o[0] !== 1'b0) begin tests_failed++; $display("FAIL load_unarmed: got %0b expected 0", armed_o[0]); end
    tm_cycles_i = 28'd1001;
    step();
    tests_run++;
    if (done_o !== 2'b01) begin tests_failed++; $display("FAIL load_done: got %0b expected 01", done_o); end
    tm_cycles_i = 28'd1999;
    arm_ch(0, 1'b0, 28'd2000, 32'd700);
    tests_run++;
    if (done_o[0] !== 1'b0) begin tests_failed++; $display("FAIL rearm_clears_done: got %0b expected 0", done_o[0]); end
    tm_cycles_i = 28'd2000;
    step();
    tests_run++;
    if (cnt(0) !== 32'd188) begin tests_failed++; $display("FAIL load_mod_p: got %0d expected 188", cnt(0)); end
  endtask

  task automatic test_snap();
    apply_reset();
    set_ch(0, 32'd0, 1'b1);
    set_ch(1, 32'd0, 1'b1);
    tm_cycles_i = 28'd124999990;
    rf_tick_i   = 2'b11;
    repeat (5) step();
    rf_tick_i   = 2'b00;
    tm_cycles_i = 28'd124999997;
    arm_ch(1, 1'b1, 28'd124999999, 32'd999);
    rf_tick_i   = 2'b11;
    tm_cycles_i = 28'd124999998;
    step();
    tm_cycles_i = 28'd124999999;
    step();
    tm_cycles_i = 28'd0;
    step();
    rf_tick_i = 2'b00;
    tests_run++;
    if (tsnap(1) !== 32'd6) begin tests_failed++; $display("FAIL snap_value: got %0d expected 6", tsnap(1)); end
    tests_run++;
    if (cnt(1) !== 32'd8) begin tests_failed++; $display("FAIL snap_counter_untouched: got %0d expected 8", cnt(1)); end
    tests_run++;
    if (cnt(0) !== 32'd8) begin tests_failed++; $display("FAIL snap_ch0_count: got %0d expected 8", cnt(0)); end
    tests_run++;
    if (tsnap(0) !== 32'd0) begin tests_failed++; $display("FAIL snap_ch0_trig: got %0d expected 0", tsnap(0)); end
    tests_run++;
    if (done_o !== 2'b10) begin tests_failed++; $display("FAIL snap_done: got %0b expected 10", done_o); end
  endtask

  task automatic test_never_match();
    logic [CW-1:0] seq [8];
    seq = '{28'd1, 28'd62500000, 28'd124999998, 28'd124999999,
            28'd0, 28'd129999999, 28'd130000000, 28'd130000001};
    apply_reset();
    set_ch(0, 32'd0, 1'b1);
    arm_ch(0, 1'b0, 28'd130000000, 32'd77);
    for (int k = 0; k < 8; k++) begin
      tm_cycles_i = seq[k];
      step();
    end
    tests_run++;
    if (armed_o[0] !== 1'b1) begin tests_failed++; $display("FAIL never_match_armed: got %0b expected 1", armed_o[0]); end
    tests_run++;
    if (cnt(0) !== 32'd0) begin tests_failed++; $display("FAIL never_match_load: got %0d expected 0", cnt(0)); end
    disarm_i[0] = 1'b1;
    step();
    disarm_i[0] = 1'b0;
    step();
    tests_run++;
    if (armed_o[0] !== 1'b0) begin tests_failed++; $display("FAIL disarm_idle: got %0b expected 0", armed_o[0]); end
    tests_run++;
    if (done_o[0] !== 1'b0) begin tests_failed++; $display("FAIL disarm_done: got %0b expected 0", done_o[0]); end
    disarm_i[0] = 1'b1;
    arm_ch(0, 1'b0, 28'd50, 32'd9);
    disarm_i[0] = 1'b0;
    tests_run++;
    if (armed_o[0] !== 1'b0) begin tests_failed++; $display("FAIL disarm_over_arm: got %0b expected 0", armed_o[0]); end
    tm_cycles_i = 28'd49;
    arm_ch(0, 1'b0, 28'd50, 32'd9);
    tm_cycles_i = 28'd50;
    disarm_i[0] = 1'b1;
    step();
    disarm_i[0] = 1'b0;
    step();
    tests_run++;
    if (cnt(0) !== 32'd0) begin tests_failed++; $display("FAIL disarm_over_match: got %0d expected 0", cnt(0)); end
    tests_run++;
    if (done_o[0] !== 1'b0) begin tests_failed++; $display("FAIL disarm_match_done: got %0b expected 0", done_o[0]); end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    set_ch(0, 32'd0, 1'b1);
    tm_cycles_i = 28'd90;
    arm_ch(0, 1'b0, 28'd100, 32'd55);
    for (int t = 91; t <= 95; t++) begin
      tm_cycles_i = CW'(t);
      step();
    end
    rst_i = 1'b1;
    tm_cycles_i = 28'd96;
    step();
    tests_run++;
    if (armed_o !== 2'b00) begin tests_failed++; $display("FAIL rst_armed: got %0b expected 00", armed_o); end
    rst_i = 1'b0;
    for (int t = 97; t <= 105; t++) begin
      tm_cycles_i = CW'(t);
      step();
    end
    tests_run++;
    if (count_o !== '0) begin tests_failed++; $display("FAIL rst_no_load: got %0h expected 0", count_o); end
    tests_run++;
    if ({armed_o, done_o, snap_valid_o} !== 5'b0) begin tests_failed++; $display("FAIL rst_flags: got %0b expected 0", {armed_o, done_o, snap_valid_o}); end
    tests_run++;
    if ({trig_snap_o, snap_rf_o} !== '0) begin tests_failed++; $display("FAIL rst_snaps: got %0h expected 0", {trig_snap_o, snap_rf_o}); end
  endtask

  task automatic test_snap_vs_load();
    apply_reset();
    set_ch(0, 32'd0, 1'b1);
    tm_cycles_i = 28'd295;
    rf_tick_i   = 2'b01;
    repeat (3) step();
    rf_tick_i   = 2'b00;
    tm_cycles_i = 28'd298;
    arm_ch(0, 1'b0, 28'd300, 32'd9);
    tm_cycles_i = 28'd299;
    step();
    tm_cycles_i = 28'd300;
    sample_p_i  = 1'b1;
    step();
    sample_p_i = 1'b0;
    tests_run++;
    if (cnt(0) !== 32'd9) begin tests_failed++; $display("FAIL coinc_load: got %0d expected 9", cnt(0)); end
    tests_run++;
    if (snap(0) !== 32'd3) begin tests_failed++; $display("FAIL coinc_snap_preload: got %0d expected 3", snap(0)); end
    tests_run++;
    if (snap_cycles_o !== 28'd300) begin tests_failed++; $display("FAIL coinc_snap_cycles: got %0d expected 300", snap_cycles_o); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_ch(0, 32'd0, 1'b1);
    tm_cycles_i = 28'd8;
    arm_ch(0, 1'b0, 28'd10, 32'd4);
    tm_cycles_i = 28'd9;
    step();
    tm_cycles_i = 28'd10;
    step();
    tm_cycles_i = 28'd11;
    arm_ch(0, 1'b0, 28'd20, 32'd6);
    tests_run++;
    if ({armed_o[0], done_o[0]} !== 2'b01) begin tests_failed++; $display("FAIL fired_ignores_arm: got %0b expected 01", {armed_o[0], done_o[0]}); end
    tm_cycles_i = 28'd20;
    step();
    tm_cycles_i = 28'd21;
    step();
    tests_run++;
    if (cnt(0) !== 32'd4) begin tests_failed++; $display("FAIL ignored_arm_no_load: got %0d expected 4", cnt(0)); end
    tm_cycles_i = 28'd25;
    arm_ch(0, 1'b0, 28'd30, 32'd1);
    tests_run++;
    if (done_o[0] !== 1'b0) begin tests_failed++; $display("FAIL arm_clears_done: got %0b expected 0", done_o[0]); end
    tm_cycles_i = 28'd26;
    arm_ch(0, 1'b0, 28'd40, 32'd2);
    tm_cycles_i = 28'd30;
    step();
    tests_run++;
    if ({armed_o[0], cnt(0)} !== {1'b1, 32'd4}) begin tests_failed++; $display("FAIL relatch_old_trig: got armed=%0b count=%0d expected armed=1 count=4", armed_o[0], cnt(0)); end
    tm_cycles_i = 28'd40;
    step();
    tests_run++;
    if (cnt(0) !== 32'd2) begin tests_failed++; $display("FAIL relatch_new_trig: got %0d expected 2", cnt(0)); end
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_free_count();
    test_period_change();
    test_wrap_free();
    test_load();
    test_snap();
    test_never_match();
    test_reset_abort();
    test_snap_vs_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
